// File: rtl/theta_div_responder.sv
// theta_div_responder: START/ACK responder computing THETA = NUM/DEN (signed Q(FRAC)) with a restoring divider. Rev 1.0
// Optional feature macro THETA_ROUND_EN: one guard-bit iteration plus round-half-up of the magnitude.
`default_nettype none

module theta_div_responder #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_clear,
  input  logic [WIDTH-1:0] i_num,
  input  logic [WIDTH-1:0] i_den,
  output logic             o_ack,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_theta,
  output logic             o_div_zero
);

`ifdef THETA_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int ITERS = WIDTH + FRAC;
  localparam int NITER = ITERS + RND;
  localparam int CW    = $clog2(NITER + 1);

  localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [ITERS:0]   LIM_POS = {{(FRAC+1){1'b0}}, SAT_POS};
  localparam logic [ITERS:0]   LIM_NEG = {{(FRAC+1){1'b0}}, SAT_NEG};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_ITER = 3'd2,
    S_FIN  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_accept;
  logic              w_load;
  logic              w_step;
  logic              w_fin;
  logic              w_busy;

  logic [WIDTH-1:0]  r_num;
  logic [WIDTH-1:0]  r_den;
  logic              r_sign;
  logic [WIDTH-1:0]  r_rem;
  logic [NITER-1:0]  r_quo;
  logic [WIDTH-1:0]  r_dvs;
  logic [CW-1:0]     r_cnt;
  logic              r_ack;
  logic              r_div_zero;
  logic [WIDTH-1:0]  r_theta;

  logic              w_den_zero;
  logic [WIDTH-1:0]  w_num_mag;
  logic [WIDTH-1:0]  w_den_mag;
  logic [WIDTH:0]    w_shift;
  logic [WIDTH:0]    w_trial;
  logic [ITERS:0]    w_mag;
  logic [WIDTH-1:0]  w_theta;

  assign w_den_zero = (r_den == '0);
  // Negating the most negative value wraps to 2^(WIDTH-1), which is the correct unsigned magnitude.
  assign w_num_mag  = r_num[WIDTH-1] ? (~r_num + 1'b1) : r_num;
  assign w_den_mag  = r_den[WIDTH-1] ? (~r_den + 1'b1) : r_den;

  assign w_shift = {r_rem, r_quo[NITER-1]};
  assign w_trial = w_shift - {1'b0, r_dvs};

`ifdef THETA_ROUND_EN
  assign w_mag = {1'b0, r_quo[NITER-1:1]} + {{ITERS{1'b0}}, r_quo[0]};
`else
  assign w_mag = {1'b0, r_quo};
`endif

  always_comb begin
    w_theta = '0;
    if (w_den_zero) begin
      w_theta = r_num[WIDTH-1] ? SAT_NEG : SAT_POS;
    end else if (!r_sign) begin
      w_theta = (w_mag > LIM_POS) ? SAT_POS : w_mag[WIDTH-1:0];
    end else begin
      w_theta = (w_mag > LIM_NEG) ? SAT_NEG : (~w_mag[WIDTH-1:0] + 1'b1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // CLEAR overrides everything, so the datapath strobes below are only raised without it.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_fin    = 1'b0;
    w_busy   = (r_state == S_LOAD) || (r_state == S_ITER) || (r_state == S_FIN);
    if (i_clear) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            w_accept = 1'b1;
            w_next   = S_LOAD;
          end
        end
        S_LOAD: begin
          w_load = 1'b1;
          w_next = w_den_zero ? S_FIN : S_ITER;
        end
        S_ITER: begin
          w_step = 1'b1;
          if (r_cnt == CW'(NITER - 1)) begin
            w_next = S_FIN;
          end
        end
        S_FIN: begin
          w_fin  = 1'b1;
          w_next = S_DONE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_num      <= '0;
      r_den      <= '0;
      r_sign     <= 1'b0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_cnt      <= '0;
      r_ack      <= 1'b0;
      r_div_zero <= 1'b0;
      r_theta    <= '0;
    end else begin
      if (w_accept) begin
        r_num <= i_num;
        r_den <= i_den;
      end

      if (w_load) begin
        r_sign <= r_num[WIDTH-1] ^ r_den[WIDTH-1];
        r_rem  <= '0;
        r_quo  <= {w_num_mag, {(FRAC+RND){1'b0}}};
        r_dvs  <= w_den_mag;
        r_cnt  <= '0;
      end else if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
        if (!w_trial[WIDTH]) begin
          r_rem <= w_trial[WIDTH-1:0];
          r_quo <= {r_quo[NITER-2:0], 1'b1};
        end else begin
          r_rem <= w_shift[WIDTH-1:0];
          r_quo <= {r_quo[NITER-2:0], 1'b0};
        end
      end

      if (i_clear || w_accept) begin
        r_ack      <= 1'b0;
        r_div_zero <= 1'b0;
      end else if (w_fin) begin
        r_ack      <= 1'b1;
        r_div_zero <= w_den_zero;
        r_theta    <= w_theta;
      end
    end
  end

  assign o_ack      = r_ack;
  assign o_busy     = w_busy;
  assign o_theta    = r_theta;
  assign o_div_zero = r_div_zero;

endmodule

`default_nettype wire

// File: tb/tb_theta_div_responder.sv
// tb_theta_div_responder: directed vectors for theta_div_responder, checked each cycle against a transaction-level model.
`default_nettype none

module tb_theta_div_responder;

  localparam int FRAC = 16;
`ifdef THETA_ROUND_EN
  localparam int LAT = 51;
  localparam bit RND = 1'b1;
  localparam logic [31:0] TWO_THIRDS = 32'h0000_AAAB;
`else
  localparam int LAT = 50;
  localparam bit RND = 1'b0;
  localparam logic [31:0] TWO_THIRDS = 32'h0000_AAAA;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        clear = 1'b0;
  logic [31:0] num   = 32'd0;
  logic [31:0] den   = 32'd0;
  logic        ack;
  logic        busy;
  logic        dz;
  logic [31:0] theta;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;
  int edge_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  theta_div_responder #(.WIDTH(32), .FRAC(FRAC)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_start    (start),
    .i_clear    (clear),
    .i_num      (num),
    .i_den      (den),
    .o_ack      (ack),
    .o_busy     (busy),
    .o_theta    (theta),
    .o_div_zero (dz)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Exact quotient by wide integer arithmetic, then rounding/saturation.
  function automatic logic [31:0] exp_theta(input logic [31:0] n, input logic [31:0] d);
    longint unsigned mn, md, q;
    if (d == 32'd0) return n[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    mn = n[31] ? (64'h1_0000_0000 - {32'd0, n}) : {32'd0, n};
    md = d[31] ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
    if (RND) q = (((mn << (FRAC + 1)) / md) + 64'd1) >> 1;
    else     q = (mn << FRAC) / md;
    if (n[31] == d[31]) return (q > 64'h7FFF_FFFF) ? 32'h7FFF_FFFF : q[31:0];
    return (q > 64'h8000_0000) ? 32'h8000_0000 : (32'd0 - q[31:0]);
  endfunction

  // Transaction-level model: a request occupies the responder for a fixed number of edges.
  logic        m_busy = 1'b0, m_ack = 1'b0, m_dz = 1'b0, m_pend_dz = 1'b0;
  logic [31:0] m_theta = 32'd0, m_pend_theta = 32'd0;
  int          m_rem = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_ack <= 1'b0; m_dz <= 1'b0; m_theta <= 32'd0; m_rem <= 0;
    end else if (clear) begin
      m_busy <= 1'b0; m_ack <= 1'b0; m_dz <= 1'b0;
    end else if (start && !m_busy) begin
      m_busy       <= 1'b1;
      m_ack        <= 1'b0;
      m_dz         <= 1'b0;
      m_rem        <= (den == 32'd0) ? 2 : LAT;
      m_pend_theta <= exp_theta(num, den);
      m_pend_dz    <= (den == 32'd0);
    end else if (m_busy) begin
      if (m_rem == 1) begin
        m_busy  <= 1'b0;
        m_ack   <= 1'b1;
        m_theta <= m_pend_theta;
        m_dz    <= m_pend_dz;
      end
      m_rem <= m_rem - 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_ack",   {31'd0, ack},  {31'd0, m_ack});
      chk("cyc_busy",  {31'd0, busy}, {31'd0, m_busy});
      chk("cyc_dz",    {31'd0, dz},   {31'd0, m_dz});
      chk("cyc_theta", theta, m_theta);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic start_op(input logic [31:0] n, input logic [31:0] d, output int st);
    num   = n;
    den   = d;
    start = 1'b1;
    tick();
    st    = edge_cnt;
    start = 1'b0;
  endtask

  task automatic wait_ack(input int st, output int lat);
    int k;
    k = 0;
    while (ack !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    if (ack !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got ack=%b expected 1 after %0d cycles", ack, k);
    end
    lat = edge_cnt - st;
  endtask

  task automatic run_op(input string name, input logic [31:0] n, input logic [31:0] d,
                        input logic [31:0] t_exp, input logic dz_exp, input int lat_exp);
    int st, lat;
    start_op(n, d, st);
    wait_ack(st, lat);
    chk({name, "_lat"},   32'(lat), 32'(lat_exp));
    chk({name, "_theta"}, theta, t_exp);
    chk({name, "_dz"},    {31'd0, dz}, {31'd0, dz_exp});
  endtask

  initial begin
    int st, lat;
    repeat (3) tick();
    cmp_en = 1'b1;
    chk("rst_ack",   {31'd0, ack},  32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_theta", theta,         32'd0);
    chk("rst_dz",    {31'd0, dz},   32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_op("p1p5", 32'h0003_0000, 32'h0002_0000, 32'h0001_8000, 1'b0, LAT);
    run_op("m3p5", 32'hFFF9_0000, 32'h0002_0000, 32'hFFFC_8000, 1'b0, LAT);
    repeat (100) tick();
    chk("ack_held", {31'd0, ack}, 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("ack_cleared",   {31'd0, ack}, 32'd0);
    chk("theta_kept",    theta, 32'hFFFC_8000);

    run_op("dz_pos", 32'h0005_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 2);
    run_op("dz_neg", 32'hFFFF_0000, 32'h0000_0000, 32'h8000_0000, 1'b1, 2);
    run_op("sat_pos", 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, LAT);
    run_op("sat_neg", 32'h8000_0000, 32'h0000_8000, 32'h8000_0000, 1'b0, LAT);
    run_op("two3rd", 32'h0000_0002, 32'h0000_0003, TWO_THIRDS, 1'b0, LAT);
    run_op("zero_num", 32'h0000_0000, 32'hFFFE_0000, 32'h0000_0000, 1'b0, LAT);

    // Second START while busy must not disturb the first request.
    start_op(32'h0003_0000, 32'h0002_0000, st);
    repeat (9) tick();
    num = 32'h0009_0000; den = 32'h0000_0000; start = 1'b1;
    tick();
    start = 1'b0;
    wait_ack(st, lat);
    chk("busy_start_lat",   32'(lat), 32'(LAT));
    chk("busy_start_theta", theta, 32'h0001_8000);

    // CLEAR mid-operation aborts it.
    start_op(32'h0005_0000, 32'h0003_0000, st);
    repeat (19) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_mid_busy", {31'd0, busy}, 32'd0);
    repeat (LAT + 5) tick();
    chk("clr_mid_ack", {31'd0, ack}, 32'd0);
    run_op("after_clr", 32'hFFF9_0000, 32'h0002_0000, 32'hFFFC_8000, 1'b0, LAT);

    // Asynchronous reset mid-operation.
    start_op(32'h0005_0000, 32'h0003_0000, st);
    repeat (19) tick();
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy",  {31'd0, busy}, 32'd0);
    chk("rstmid_theta", theta, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (LAT + 5) tick();
    chk("rstmid_ack", {31'd0, ack}, 32'd0);
    run_op("after_rst", 32'h0000_0002, 32'h0000_0003, TWO_THIRDS, 1'b0, LAT);

    // CLEAR and START together while ACK is high: CLEAR wins.
    clear = 1'b1; start = 1'b1; num = 32'h0003_0000; den = 32'h0002_0000;
    tick();
    clear = 1'b0; start = 1'b0;
    chk("clr_start_ack",  {31'd0, ack},  32'd0);
    chk("clr_start_busy", {31'd0, busy}, 32'd0);
    repeat (3) tick();
    chk("clr_start_idle", {31'd0, busy}, 32'd0);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
